// File: rtl/huff_decoder_if.sv
// Word-stream bus between the bitstream source and the Huffman decoder.
interface huff_decoder_if;
  logic       in_valid;
  logic [1:0] in_type;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       table_loaded;
  logic       done;
  logic       error;

  modport master (
    output in_valid, in_type, in_data,
    input  in_ready, out_valid, out_char, table_loaded, done, error
  );

  modport slave (
    input  in_valid, in_type, in_data,
    output in_ready, out_valid, out_char, table_loaded, done, error
  );
endinterface

// File: rtl/huff_decoder.sv
// Huffman decoder: loads a char/mask/value code table, then turns a serial
// bitstream into one decoded character per completed codeword.
module huff_decoder #(
  parameter int unsigned MAX_CHAR_COUNT = 3,
  parameter int unsigned CODE_W         = 4
) (
  input logic           clk,
  input logic           reset,
  huff_decoder_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(CODE_W + 1);
  localparam int unsigned CNT_W = $clog2(MAX_CHAR_COUNT + 1);

  localparam logic [1:0] T_CHAR = 2'b00;
  localparam logic [1:0] T_CODE = 2'b01;
  localparam logic [1:0] T_BIT  = 2'b10;
  localparam logic [1:0] T_EOS  = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD_CODE, LOAD_CHAR, DECODE, ERROR} state_t;

  typedef struct packed {
    logic [7:0]        ch;
    logic [CODE_W-1:0] mask;
    logic [CODE_W-1:0] value;
  } entry_t;

  state_t            state_q, state_d;
  entry_t            tbl_q [MAX_CHAR_COUNT];
  entry_t            tbl_d [MAX_CHAR_COUNT];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] acc_q, acc_d, nacc;
  logic [LEN_W-1:0]  len_q, len_d, nlen;
  logic              loaded_q, loaded_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        out_char_q, out_char_d;
  logic              accept, hit, mask_ok;
  logic [7:0]        hit_char;
  logic [CODE_W-1:0] code_mask;

  function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] m);
    logic [LEN_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < CODE_W; i++) c = c + LEN_W'(m[i]);
    return c;
  endfunction

  assign bus.in_ready     = (state_q != ERROR);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_char     = out_char_q;
  assign bus.table_loaded = loaded_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

  assign accept = bus.in_valid && bus.in_ready;

  // Next-state, table update and output pulses.
  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    len_d       = len_q;
    loaded_d    = loaded_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    out_char_d  = out_char_q;

    nacc      = {acc_q[CODE_W-2:0], bus.in_data[0]};
    nlen      = len_q + LEN_W'(1);
    code_mask = bus.in_data[2*CODE_W-1:CODE_W];
    // Length comes from popcount, so the mask must be a nonzero run of ones from the LSB.
    mask_ok   = (code_mask != '0) && ((code_mask & (code_mask + CODE_W'(1))) == '0);

    // Lowest-indexed matching entry wins.
    hit      = 1'b0;
    hit_char = '0;
    for (int unsigned k = 0; k < MAX_CHAR_COUNT; k++) begin
      if (!hit && nlen == popcount(tbl_q[k].mask) &&
          (nacc & tbl_q[k].mask) == tbl_q[k].value) begin
        hit      = 1'b1;
        hit_char = tbl_q[k].ch;
      end
    end

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (bus.in_type == T_CHAR) begin
            tbl_d[0].ch = bus.in_data;
            cnt_d       = '0;
            state_d     = LOAD_CODE;
          end else begin
            state_d = ERROR;
          end
        end
        LOAD_CODE: begin
          if (bus.in_type == T_CODE && mask_ok) begin
            tbl_d[cnt_q].mask  = code_mask;
            tbl_d[cnt_q].value = bus.in_data[CODE_W-1:0];
            cnt_d              = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_W'(MAX_CHAR_COUNT)) begin
              state_d  = DECODE;
              loaded_d = 1'b1;
            end else begin
              state_d = LOAD_CHAR;
            end
          end else begin
            state_d = ERROR;
          end
        end
        LOAD_CHAR: begin
          if (bus.in_type == T_CHAR) begin
            tbl_d[cnt_q].ch = bus.in_data;
            state_d         = LOAD_CODE;
          end else begin
            state_d = ERROR;
          end
        end
        DECODE: begin
          case (bus.in_type)
            T_BIT: begin
              if (hit) begin
                out_valid_d = 1'b1;
                out_char_d  = hit_char;
                acc_d       = '0;
                len_d       = '0;
              end else if (nlen == LEN_W'(CODE_W)) begin
                state_d = ERROR;
              end else begin
                acc_d = nacc;
                len_d = nlen;
              end
            end
            T_EOS: begin
              if (len_q == '0) done_d = 1'b1;
              else             state_d = ERROR;
            end
            T_CHAR: begin
              tbl_d       = '{default: '0};
              tbl_d[0].ch = bus.in_data;
              cnt_d       = '0;
              acc_d       = '0;
              len_d       = '0;
              loaded_d    = 1'b0;
              state_d     = LOAD_CODE;
            end
            default: state_d = ERROR;
          endcase
        end
        default: ;
      endcase
    end

    error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tbl_q       <= '{default: '0};
      cnt_q       <= '0;
      acc_q       <= '0;
      len_q       <= '0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      out_char_q  <= '0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      loaded_q    <= loaded_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
      out_char_q  <= out_char_d;
    end
  end
endmodule

// File: tb/tb_huff_decoder.sv
// Directed bench for huff_decoder with a scoreboard of expected characters.
module tb_huff_decoder;
  localparam logic [1:0] T_CHAR = 2'b00;
  localparam logic [1:0] T_CODE = 2'b01;
  localparam logic [1:0] T_BIT  = 2'b10;
  localparam logic [1:0] T_EOS  = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] sb[$];
  logic [7:0] mon_exp_c;
  logic       mon_exp_v;

  huff_decoder_if bus ();

  huff_decoder #(.MAX_CHAR_COUNT(3), .CODE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one word for one cycle; pulse says whether out_valid must follow the edge.
  task automatic send(input logic [1:0] t, input logic [7:0] d,
                      input logic pulse, input logic [7:0] ch);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_type  = t;
    bus.in_data  = d;
    if (pulse) sb.push_back(ch);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("out_valid_latency", 8'(bus.out_valid), 8'(pulse));
  endtask

  task automatic bit_w(input logic b, input logic pulse, input logic [7:0] ch);
    send(T_BIT, {7'b0, b}, pulse, ch);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 8'(bus.out_valid), 8'h00);
    chk("rst_done", 8'(bus.done), 8'h00);
    chk("rst_error", 8'(bus.error), 8'h00);
    chk("rst_table_loaded", 8'(bus.table_loaded), 8'h00);
    chk("rst_out_char", bus.out_char, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 8'(bus.in_ready), 8'h01);
  endtask

  task automatic load_basic();
    send(T_CHAR, 8'h61, 1'b0, 8'h00);
    send(T_CODE, 8'h10, 1'b0, 8'h00);
    send(T_CHAR, 8'h6E, 1'b0, 8'h00);
    send(T_CODE, 8'h32, 1'b0, 8'h00);
    chk("table_loaded_early", 8'(bus.table_loaded), 8'h00);
    send(T_CHAR, 8'h6D, 1'b0, 8'h00);
    send(T_CODE, 8'h33, 1'b0, 8'h00);
    chk("table_loaded", 8'(bus.table_loaded), 8'h01);
  endtask

  // Every out_valid pulse must pop a queued character and match it.
  always @(posedge clk) begin
    #1;
    if (bus.out_valid === 1'b1) begin
      mon_exp_v = (sb.size() != 0);
      chk("out_valid_expected", 8'(bus.out_valid), 8'(mon_exp_v));
      if (mon_exp_v) begin
        mon_exp_c = sb.pop_front();
        chk("out_char", bus.out_char, mon_exp_c);
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_type  = T_CHAR;
    bus.in_data  = 8'h00;
    idle(2);
    do_reset();

    // Basic decode: a=0, n=10, m=11
    load_basic();
    bit_w(1'b0, 1'b1, 8'h61);
    bit_w(1'b1, 1'b0, 8'h00);
    bit_w(1'b0, 1'b1, 8'h6E);
    bit_w(1'b1, 1'b0, 8'h00);
    bit_w(1'b1, 1'b1, 8'h6D);
    chk("out_char_hold", bus.out_char, 8'h6D);
    send(T_EOS, 8'h00, 1'b0, 8'h00);
    chk("done", 8'(bus.done), 8'h01);
    chk("error_clean", 8'(bus.error), 8'h00);
    idle(1);
    #1;
    chk("done_one_cycle", 8'(bus.done), 8'h00);

    // Idle gaps inside a codeword
    bit_w(1'b1, 1'b0, 8'h00);
    idle(3);
    bit_w(1'b0, 1'b1, 8'h6E);
    idle(2);

    // Partial codeword at end-of-stream
    bit_w(1'b1, 1'b0, 8'h00);
    send(T_EOS, 8'h00, 1'b0, 8'h00);
    chk("partial_error", 8'(bus.error), 8'h01);
    chk("partial_in_ready", 8'(bus.in_ready), 8'h00);
    chk("partial_no_done", 8'(bus.done), 8'h00);
    bit_w(1'b0, 1'b0, 8'h00);
    bit_w(1'b1, 1'b0, 8'h00);
    chk("error_sticky", 8'(bus.error), 8'h01);
    do_reset();

    // Code word while idle
    send(T_CODE, 8'h10, 1'b0, 8'h00);
    chk("idle_code_error", 8'(bus.error), 8'h01);
    do_reset();

    // Bit word while waiting for a char
    send(T_CHAR, 8'h61, 1'b0, 8'h00);
    send(T_CODE, 8'h10, 1'b0, 8'h00);
    bit_w(1'b0, 1'b0, 8'h00);
    chk("load_char_bit_error", 8'(bus.error), 8'h01);
    do_reset();

    // Non-contiguous mask is rejected at load time
    send(T_CHAR, 8'h61, 1'b0, 8'h00);
    send(T_CODE, 8'h50, 1'b0, 8'h00);
    chk("bad_mask_error", 8'(bus.error), 8'h01);
    do_reset();

    // Table reload: x=1, y=00, z=10
    load_basic();
    bit_w(1'b0, 1'b1, 8'h61);
    send(T_CHAR, 8'h78, 1'b0, 8'h00);
    chk("reload_drops_loaded", 8'(bus.table_loaded), 8'h00);
    send(T_CODE, 8'h11, 1'b0, 8'h00);
    send(T_CHAR, 8'h79, 1'b0, 8'h00);
    send(T_CODE, 8'h30, 1'b0, 8'h00);
    send(T_CHAR, 8'h7A, 1'b0, 8'h00);
    send(T_CODE, 8'h32, 1'b0, 8'h00);
    chk("reload_loaded", 8'(bus.table_loaded), 8'h01);
    bit_w(1'b1, 1'b1, 8'h78);
    bit_w(1'b0, 1'b0, 8'h00);
    bit_w(1'b0, 1'b1, 8'h79);
    // z=10 is shadowed by x=1, so the trailing 0,1 stays a partial codeword
    bit_w(1'b0, 1'b0, 8'h00);
    bit_w(1'b1, 1'b0, 8'h00);
    send(T_EOS, 8'h00, 1'b0, 8'h00);
    chk("reload_partial_error", 8'(bus.error), 8'h01);
    do_reset();

    // Lowest-index wins when entries overlap
    send(T_CHAR, 8'h41, 1'b0, 8'h00);
    send(T_CODE, 8'h30, 1'b0, 8'h00);
    send(T_CHAR, 8'h42, 1'b0, 8'h00);
    send(T_CODE, 8'h30, 1'b0, 8'h00);
    send(T_CHAR, 8'h43, 1'b0, 8'h00);
    send(T_CODE, 8'hF0, 1'b0, 8'h00);
    bit_w(1'b0, 1'b0, 8'h00);
    bit_w(1'b0, 1'b1, 8'h41);
    // No match by the fourth bit is a decode error
    bit_w(1'b1, 1'b0, 8'h00);
    bit_w(1'b1, 1'b0, 8'h00);
    bit_w(1'b1, 1'b0, 8'h00);
    chk("no_match_not_yet", 8'(bus.error), 8'h00);
    bit_w(1'b1, 1'b0, 8'h00);
    chk("no_match_error", 8'(bus.error), 8'h01);
    do_reset();

    // Reset mid-load abandons the partial table
    send(T_CHAR, 8'h61, 1'b0, 8'h00);
    send(T_CODE, 8'h10, 1'b0, 8'h00);
    send(T_CHAR, 8'h6E, 1'b0, 8'h00);
    send(T_CODE, 8'h32, 1'b0, 8'h00);
    do_reset();
    load_basic();
    bit_w(1'b0, 1'b1, 8'h61);
    idle(2);

    chk("scoreboard_empty", 8'(sb.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
